// File: rtl/quad_window_unpacker_pkg.sv
// Shared definitions for the packed quad-index interface: lane count, FSM states,
// and the modular helpers used by both the index generator and the unpacker.
package quad_window_unpacker_pkg;

  localparam int LANES = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int lane_w(input int size);
    return $clog2(size);
  endfunction

  // Operands are assumed below size, so subtracting once is enough to wrap.
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned size);
    int unsigned sum;
    sum = a + b;
    if (sum >= size) sum = sum - size;
    return sum;
  endfunction

endpackage

// File: rtl/quad_window_unpacker_checker.sv
// quad_seq_checker: combinational test that four packed lanes form a run
// lane0, lane0+1, lane0+2, lane0+3 modulo SIZE, with every lane in range.
module quad_seq_checker
  import quad_window_unpacker_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int W    = lane_w(SIZE)
) (
  input  logic [LANES*W-1:0] lanes,
  output logic               mismatch
);

  logic [W-1:0] lane0;

  assign lane0 = lanes[W-1:0];

  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (32'(lanes[W*(i+1)-1 -: W]) >= 32'(SIZE)) mismatch = 1'b1;
      if ((i > 0) &&
          (32'(lanes[W*(i+1)-1 -: W]) != wrap_add(32'(lane0), 32'(i), 32'(SIZE))))
        mismatch = 1'b1;
    end
  end

endmodule

// File: rtl/quad_window_unpacker.sv
// Accepts one packed 4-lane index word and emits it one lane per handshake,
// flagging non-consecutive words. Optional QUAD_UNPACK_ERRCNT_EN adds err_count.
module quad_window_unpacker
  import quad_window_unpacker_pkg::*;
#(
  parameter  int SIZE = 16,
  localparam int W    = lane_w(SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] num_in,
  output logic               elem_valid,
  input  logic               elem_ready,
  output logic [W-1:0]       elem_out,
  output logic [1:0]         elem_idx,
  output logic               elem_last,
  output logic [W-1:0]       base_out,
  output logic               seq_err
`ifdef QUAD_UNPACK_ERRCNT_EN
  ,
  output logic [15:0]        err_count
`endif
);

  state_t             state;
  state_t             state_next;
  logic [LANES*W-1:0] buffer;
  logic [1:0]         idx;
  logic               word_err;
  logic               mismatch;
  logic               accept;
  logic               beat;

  quad_seq_checker #(
    .SIZE(SIZE),
    .W   (W)
  ) u_checker (
    .lanes   (num_in),
    .mismatch(mismatch)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A new word can only enter on the final beat, which keeps back-to-back words bubble-free.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    elem_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = DRAIN;
      end
      DRAIN: begin
        elem_valid = 1'b1;
        in_ready   = (idx == 2'd3) && elem_ready;
        if (in_ready && !in_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign beat      = elem_valid & elem_ready;
  assign elem_last = elem_valid & (idx == 2'd3);
  assign elem_out  = buffer[W*idx +: W];
  assign elem_idx  = idx;
  assign seq_err   = elem_last & word_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer   <= '0;
      base_out <= '0;
      idx      <= 2'd0;
      word_err <= 1'b0;
    end else if (accept) begin
      buffer   <= num_in;
      base_out <= num_in[W-1:0];
      idx      <= 2'd0;
      word_err <= mismatch;
    end else if (beat) begin
      idx <= idx + 2'd1;
    end
  end

`ifdef QUAD_UNPACK_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 16'd0;
    end else if (beat && seq_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
